// File: rtl/trace_buffer.sv
// trace_buffer: circular capture of packed vectors while tracing, drained oldest-first over valid/ready
module trace_buffer #(
  parameter int N                     = 8,
  parameter int DATA_WIDTH            = 32,
  parameter int TB_SIZE               = 64,
  parameter int PERSONAL_CONFIG_ID    = 7,
  parameter int INITIAL_FIRMWARE_MODE = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                tracing,
  input  logic                                valid_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]        vector_in,
  input  logic [7:0]                          configId,
  input  logic [7:0]                          configData,
  input  logic                                rd_ready,
  output logic [N-1:0][DATA_WIDTH-1:0]        vector_out,
  output logic                                valid_out,
  output logic [$clog2(TB_SIZE):0]            count,
  output logic                                full,
  output logic [15:0]                         drop_count
);
  localparam int PW = $clog2(TB_SIZE);
  localparam int CW = PW + 1;
  localparam int VW = N * DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, TRACE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [VW-1:0] mem [TB_SIZE];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wp, rp;
  logic [CW-1:0] count_q, count_d, cnt, pending;
  logic [15:0] drop_count_q, drop_count_d, drops;
  logic [VW-1:0] vec_q, vec_d;
  logic mode_q, mode_d, valid_q, valid_d, start, we, is_full, load, hs;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(TB_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    start        = tracing && state_q != TRACE;
    wp           = start ? '0 : wr_ptr_q;
    rp           = start ? '0 : rd_ptr_q;
    cnt          = start ? '0 : count_q;
    drops        = start ? '0 : drop_count_q;
    is_full      = cnt == CW'(TB_SIZE);
    we           = tracing && valid_in && (!is_full || !mode_q);
    hs           = valid_q && rd_ready;
    pending      = count_q - CW'(valid_q);
    load         = state_q == DRAIN && !tracing && pending != '0 && (!valid_q || rd_ready);
    wr_ptr_d     = we ? nxt(wp) : wp;
    rd_ptr_d     = ((we && is_full) || load) ? nxt(rp) : rp;
    count_d      = tracing ? cnt + CW'(we && !is_full) : count_q - CW'(hs);
    drop_count_d = drops + 16'(tracing && valid_in && is_full && mode_q && drops != 16'hFFFF);
    valid_d      = start ? 1'b0 : load ? 1'b1 : hs ? 1'b0 : valid_q;
    vec_d        = load ? mem[rd_ptr_q] : vec_q;
    mode_d       = (!tracing && configId == 8'(PERSONAL_CONFIG_ID)) ? configData[0] : mode_q;
    state_d      = tracing ? TRACE :
                   state_q == TRACE ? (count_q != '0 ? DRAIN : IDLE) :
                   (state_q == DRAIN && count_d == '0) ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (we) mem[wp] <= vector_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_count_q <= '0;
      valid_q      <= 1'b0;
      vec_q        <= '0;
      mode_q       <= INITIAL_FIRMWARE_MODE[0];
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_count_q <= drop_count_d;
      valid_q      <= valid_d;
      vec_q        <= vec_d;
      mode_q       <= mode_d;
    end
  end
  assign vector_out = vec_q;
  assign valid_out  = valid_q;
  assign count      = count_q;
  assign full       = count_q == CW'(TB_SIZE);
  assign drop_count = drop_count_q;
endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer: directed scoreboard bench for trace_buffer with a 4-deep buffer
module tb_trace_buffer;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int SZ = 4;
  localparam int VW = N * DW;
  logic clk = 1'b0, rst = 1'b1, tracing = 1'b0, valid_in = 1'b0, rd_ready = 1'b0;
  logic [N-1:0][DW-1:0] vector_in = '0, vector_out;
  logic [7:0] configId = '0, configData = '0;
  logic valid_out, full;
  logic [$clog2(SZ):0] count;
  logic [15:0] drop_count;
  logic [VW-1:0] q[$];
  int tb_mode = 0, tb_drops = 0, checks = 0, errors = 0, n;
  trace_buffer #(.N(N), .DATA_WIDTH(DW), .TB_SIZE(SZ), .PERSONAL_CONFIG_ID(7), .INITIAL_FIRMWARE_MODE(0)) dut (
    .clk(clk), .rst(rst), .tracing(tracing), .valid_in(valid_in), .vector_in(vector_in),
    .configId(configId), .configData(configData), .rd_ready(rd_ready), .vector_out(vector_out),
    .valid_out(valid_out), .count(count), .full(full), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  function automatic logic [VW-1:0] vec(input int v);
    return {N{DW'(v)}};
  endfunction
  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr_vec(input int v);
    if (!tracing) begin
      q.delete();
      tb_drops = 0;
    end
    tracing = 1'b1;
    valid_in = 1'b1;
    configId = 8'd7;
    configData = 8'h00;
    vector_in = vec(v);
    if (q.size() < SZ) q.push_back(vec(v));
    else if (tb_mode == 0) begin
      void'(q.pop_front());
      q.push_back(vec(v));
    end else tb_drops++;
    cyc();
    valid_in = 1'b0;
  endtask
  task automatic wr_range(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) wr_vec(v);
  endtask
  task automatic drain(input logic [15:0] mask, input int stop_after, output int cycles);
    logic stall = 1'b0;
    logic [VW-1:0] held = '0;
    int hs = 0;
    bit done = 0;
    tracing = 1'b0;
    valid_in = 1'b0;
    configId = 8'd0;
    cycles = 0;
    while (!done && cycles < 200) begin
      rd_ready = (cycles < 16) ? mask[cycles] : 1'b1;
      chk("count", VW'(count), VW'(q.size()));
      chk("full", VW'(full), VW'(q.size() == SZ));
      if (stall) chk("stall_hold", {vector_out[0], 31'd0, valid_out}, {held[DW-1:0], 31'd0, 1'b1});
      if (q.size() == 0 && !valid_out) done = 1;
      else begin
        stall = valid_out && !rd_ready;
        held = vector_out;
        if (valid_out && rd_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $error("FAIL extra_output: observed %0h expected none", vector_out);
          end else chk("drain_data", vector_out, q.pop_front());
          hs++;
        end
        cyc();
        cycles++;
        if (stop_after > 0 && hs == stop_after) done = 1;
      end
    end
    if (!done) begin
      errors++;
      $error("FAIL drain_timeout: observed %0d cycles expected under 200", cycles);
    end
  endtask
  initial begin
    cyc();
    cyc();
    chk("rst_valid", VW'(valid_out), '0);
    chk("rst_vector", vector_out, '0);
    chk("rst_count", VW'(count), '0);
    chk("rst_full", VW'(full), '0);
    chk("rst_drop", VW'(drop_count), '0);
    rst = 1'b0;
    cyc();
    wr_range(1, 3);
    drain(16'hFFFF, 0, n);
    chk("drain3_latency", VW'(n), VW'(5));
    chk("idle_valid", VW'(valid_out), '0);
    wr_range(1, 6);
    chk("wrap_full", VW'(full), VW'(1));
    chk("wrap_count", VW'(count), VW'(4));
    chk("wrap_drop", VW'(drop_count), '0);
    drain(16'hFFFF, 0, n);
    configId = 8'd7;
    configData = 8'h01;
    cyc();
    tb_mode = 1;
    wr_range(1, 6);
    chk("stop_drop", VW'(drop_count), VW'(tb_drops));
    chk("stop_full", VW'(full), VW'(1));
    drain(16'hFFFF, 0, n);
    wr_range(1, 4);
    drain(16'hFFE7, 0, n);
    wr_range(1, 4);
    drain(16'hFFFF, 2, n);
    wr_vec(9);
    chk("retrace_valid", VW'(valid_out), '0);
    chk("retrace_count", VW'(count), VW'(1));
    drain(16'hFFFF, 0, n);
    wr_range(1, 3);
    drain(16'hFFFF, 1, n);
    rst = 1'b1;
    tracing = 1'b0;
    cyc();
    rst = 1'b0;
    tb_mode = 0;
    q.delete();
    chk("mid_rst_valid", VW'(valid_out), '0);
    chk("mid_rst_vector", vector_out, '0);
    chk("mid_rst_count", VW'(count), '0);
    wr_range(1, 6);
    chk("mode_revert_drop", VW'(drop_count), '0);
    chk("mode_revert_count", VW'(count), VW'(4));
    drain(16'hFFFF, 0, n);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/trace_buffer.md
# trace_buffer

Circular trace buffer that captures the packed N-lane vectors produced by the data packer while `tracing` is high and drains them oldest-first over a valid/ready port once `tracing` drops. It sits directly downstream of the data packer (`vector_in`/`valid_in` are the packer's `vector_out`/`valid_out`) and feeds the host readout path. A per-block config byte selects between wrap-around (keep newest) and stop-on-full (keep oldest) capture.

## Interface
- N, 8, lanes per vector
- DATA_WIDTH, 32, bits per lane
- TB_SIZE, 64, buffer depth in vectors (≥2, any integer)
- PERSONAL_CONFIG_ID, 7, configId value addressing this block
- INITIAL_FIRMWARE_MODE, 0, reset/initial capture mode (0 wrap, 1 stop-on-full)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- tracing  in  1  capture phase when high; drain/config phase when low
- valid_in  in  1  vector_in valid
- vector_in  in  [DATA_WIDTH-1:0] x N  packed vector
- configId  in  8  config target id
- configData  in  8  config byte
- rd_ready  in  1  consumer accepts vector_out this cycle
- vector_out  out  [DATA_WIDTH-1:0] x N  drained vector (registered)
- valid_out  out  1  vector_out valid
- count  out  $clog2(TB_SIZE)+1  entries stored and not yet accepted by consumer
- full  out  1  count == TB_SIZE
- drop_count  out  16  vectors discarded in stop-on-full mode, saturating

## Operation
- Storage: TB_SIZE x (N·DATA_WIDTH); wr_ptr, rd_ptr wrap TB_SIZE-1 → 0 explicitly (no power-of-two assumption).
- FSM states IDLE, TRACE, DRAIN; reset → IDLE.
  - IDLE/DRAIN → TRACE when tracing=1: pointers, count, drop_count cleared; valid_out cleared. A valid_in in that same cycle is written to slot 0 (count=1 after the edge).
  - TRACE → DRAIN when tracing=0 and count>0; TRACE → IDLE when tracing=0 and count=0.
  - DRAIN → IDLE when count reaches 0 (last handshake).
- Write: accepted iff tracing=1 and valid_in=1 (state irrelevant), writes mem[wr_ptr], wr_ptr++.
  - Not full: count++.
  - Full, mode 0: overwrite oldest; rd_ptr++ with wr_ptr; count stays TB_SIZE.
  - Full, mode 1: write dropped, pointers unchanged, drop_count++ saturating at 16'hFFFF.
- valid_in ignored while tracing=0.
- Drain (DRAIN only): pending = count − valid_out. Output register loads mem[rd_ptr], rd_ptr++, valid_out=1 when pending>0 and (valid_out=0 or rd_ready=1). Handshake = valid_out & rd_ready → count−−; if nothing loads that edge, valid_out→0. Order strictly oldest → newest.
- vector_out and valid_out held stable while valid_out=1 and rd_ready=0.
- Config: when tracing=0 and configId==PERSONAL_CONFIG_ID, mode ← configData[0] at the edge; other bits ignored. Applies from the next TRACE. Config ignored while tracing=1.
- Reset: valid_out=0, vector_out all zero, count=0, full=0, drop_count=0, pointers 0, mode=INITIAL_FIRMWARE_MODE, state IDLE; memory contents are don't-care. Reset overrides all other events, including mid-drain.

## Timing
- Write → count/full visible 1 cycle after the accepting edge.
- tracing sampled low at edge E: state=DRAIN after E; first valid_out=1 after E+1 (2 cycles of latency from the first low cycle).
- Steady drain with rd_ready=1: one vector per cycle, no bubbles.
- After a handshake with pending=0: valid_out=0 next cycle, state IDLE.
- tracing sampled high in DRAIN at edge E: after E valid_out=0, count ∈ {0,1} per that cycle's valid_in; undrained data is lost.
- Simultaneous write-when-full (mode 0): count unchanged, full stays 1.

## Test plan
- TB_SIZE=4, mode 0: write vectors with all lanes 1,2,3; drop tracing, rd_ready=1 → valid_out on 3 consecutive cycles with lanes 1,2,3; count 3→2→1→0; then IDLE, valid_out=0.
- Mode 0, write 1..6 → full=1, count=4, drop_count=0; drain yields 3,4,5,6.
- Config mode 1 (configId=7, configData=8'h01, tracing=0), then write 1..6 → drain yields 1,2,3,4; drop_count=2.
- Backpressure during drain of 1..4 with rd_ready pattern 1,0,0,1,1,1 → vector_out holds 2 through both stall cycles; sequence 1,2,3,4 with no loss or duplicate.
- Write 1..4, drain 2, raise tracing with valid_in=1 (lanes 9) → next cycle valid_out=0, count=1; drop tracing → drain yields only 9.
- Reset asserted mid-drain → next cycle valid_out=0, vector_out=0, count=0, mode reverts to INITIAL_FIRMWARE_MODE.
